// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32 funct3 access-type encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - state_t, the FSM state encoding used by lsu_mem_ctrl
//   - decode_size(): access size in bytes and the unshifted byte mask
//   - f3_legal(): whether a funct3 is a valid access for a load or a store
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0] size;       // bytes: 1, 2 or 4 (0 for illegal encodings)
    logic [3:0] base_mask;  // byte mask before shifting into the lane
  } acc_size_t;

  function automatic acc_size_t decode_size(input logic [2:0] f3);
    acc_size_t r;
    case (f3)
      F3_B, F3_BU: r = '{size: 3'd1, base_mask: 4'b0001};
      F3_H, F3_HU: r = '{size: 3'd2, base_mask: 4'b0011};
      F3_W:        r = '{size: 3'd4, base_mask: 4'b1111};
      default:     r = '{size: 3'd0, base_mask: 4'b0000};
    endcase
    return r;
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the LSU.
// The access is viewed as a 64-bit window spanning word and word+1:
//   store side: byte mask and write data shifted into lane position, split into
//               the LO (word) and HI (word+1) halves
//   load side : the {hi, lo} read pair shifted down by the byte offset,
//               truncated to the access size and sign/zero extended
// Ports:
//   funct3, off      access type and byte offset within the word
//   wdata            right-aligned store data
//   rd_lo, rd_hi     read data of word and word+1 (rd_hi = 0 for single beats)
//   lo_wdata/lo_mask write data / byte enables of the LO beat
//   hi_wdata/hi_mask write data / byte enables of the HI beat
//   split            access crosses the word boundary (off + size > 4)
//   ld_data          extended load result
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [31:0] lo_wdata,
  output logic [31:0] hi_wdata,
  output logic [3:0]  lo_mask,
  output logic [3:0]  hi_mask,
  output logic        split,
  output logic [31:0] ld_data
);

  acc_size_t   acc;
  logic [4:0]  shamt;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [31:0] ld_word;

  // NOTE: every variable written here gets a value on every path (the case
  // has a default), otherwise synthesis would infer latches.
  always_comb begin
    acc     = decode_size(funct3);
    shamt   = {off, 3'b000};
    mask8   = {4'b0000, acc.base_mask} << off;
    data64  = {32'b0, wdata} << shamt;
    split   = ({2'b00, off} + {1'b0, acc.size}) > 4'd4;
    ld_word = 32'({rd_hi, rd_lo} >> shamt);
    case (funct3)
      F3_B:    ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      F3_H:    ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'b0, ld_word[7:0]};
      F3_HU:   ld_data = {16'b0, ld_word[15:0]};
      default: ld_data = '0;
    endcase
  end

  assign lo_mask  = mask8[3:0];
  assign hi_mask  = mask8[7:4];
  assign lo_wdata = data64[31:0];
  assign hi_wdata = data64[63:32];

endmodule

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store unit driving a byte-masked, combinationally read data memory.
// One request is accepted per i_req & o_ready handshake; the FSM then runs
// IDLE -> LO [-> HI] -> RESP -> IDLE. A word-crossing access uses the HI beat
// at word+1 (wrapping modulo 2^MEM_AW). Illegal funct3 skips memory entirely
// and answers with o_err=1, o_rdata=0.
//
// Build option: LSU_MISALIGN_EN
//   defined   : word-crossing accesses run as two beats (LO then HI)
//   undefined : HI beat and its capture register are absent; a crossing
//               access is answered like an illegal one (no beat, o_err=1)
//
// Parameters: MEM_AW  word-address width of the memory port
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req, i_we, i_funct3,
//   i_addr, i_wdata         core request (store data right-aligned)
//   o_ready                 idle, request accepted this cycle if i_req
//   o_done, o_rdata, o_err  one-cycle completion; o_rdata held until next done
//   o_mem_addr, o_mem_wdata,
//   o_mem_bmask, o_mem_wren memory port (all zero outside LO/HI)
//   i_mem_rdata             memory read data for o_mem_addr
// -----------------------------------------------------------------------------
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 11
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        wren_q;

  logic [MEM_AW-1:0] in_word;
  logic              unused_addr_hi;

  // Upper address bits beyond the memory are deliberately ignored.
  assign in_word        = i_addr[MEM_AW+1:2];
  assign unused_addr_hi = ^i_addr[31:MEM_AW+2];

  // The aligner sees the live request while idle (to set up the LO beat on
  // the accept edge) and the latched request once the access is in flight.
  logic [2:0]  req_f3;
  logic [1:0]  req_off;
  logic [31:0] req_wdata;

  assign req_f3    = (state == IDLE) ? i_funct3    : f3_q;
  assign req_off   = (state == IDLE) ? i_addr[1:0] : off_q;
  assign req_wdata = (state == IDLE) ? i_wdata     : wdata_q;

  logic [31:0] ld_lo, ld_hi;
  logic [31:0] lo_wdata, hi_wdata, ld_data;
  logic [3:0]  lo_mask, hi_mask;
  logic        split;

`ifdef LSU_MISALIGN_EN
  logic [MEM_AW-1:0] word_q;
  logic [31:0]       lo_q;    // LO beat read data, kept for the HI beat

  assign ld_lo = (state == HI) ? lo_q        : i_mem_rdata;
  assign ld_hi = (state == HI) ? i_mem_rdata : 32'b0;
`else
  logic unused_hi_lane;

  assign ld_lo          = i_mem_rdata;
  assign ld_hi          = 32'b0;
  assign unused_hi_lane = ^{hi_wdata, hi_mask};
`endif

  lsu_align u_align (
    .funct3   (req_f3),
    .off      (req_off),
    .wdata    (req_wdata),
    .rd_lo    (ld_lo),
    .rd_hi    (ld_hi),
    .lo_wdata (lo_wdata),
    .hi_wdata (hi_wdata),
    .lo_mask  (lo_mask),
    .hi_mask  (hi_mask),
    .split    (split),
    .ld_data  (ld_data)
  );

  // Gating with reset keeps an in-flight beat from committing on the reset edge.
  assign o_mem_wren = wren_q & ~i_reset;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      o_ready     <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      wren_q      <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
`ifdef LSU_MISALIGN_EN
      word_q      <= '0;
      lo_q        <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            we_q    <= i_we;
            f3_q    <= i_funct3;
            off_q   <= i_addr[1:0];
            wdata_q <= i_wdata;
            o_ready <= 1'b0;
`ifdef LSU_MISALIGN_EN
            word_q  <= in_word;
            if (!f3_legal(i_we, i_funct3)) begin
`else
            if (!f3_legal(i_we, i_funct3) || split) begin
`endif
              state   <= RESP;
              o_done  <= 1'b1;
              o_err   <= 1'b1;
              o_rdata <= '0;
            end else begin
              state       <= LO;
              o_mem_addr  <= in_word;
              o_mem_wdata <= lo_wdata;
              o_mem_bmask <= lo_mask;
              wren_q      <= i_we;
            end
          end
        end

        LO: begin
`ifdef LSU_MISALIGN_EN
          if (split) begin
            state       <= HI;
            lo_q        <= i_mem_rdata;
            o_mem_addr  <= word_q + MEM_AW'(1);
            o_mem_wdata <= hi_wdata;
            o_mem_bmask <= hi_mask;
          end else
`endif
          begin
            state       <= RESP;
            o_done      <= 1'b1;
            o_err       <= 1'b0;
            if (!we_q) o_rdata <= ld_data;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            wren_q      <= 1'b0;
          end
        end

`ifdef LSU_MISALIGN_EN
        HI: begin
          state       <= RESP;
          o_done      <= 1'b1;
          o_err       <= 1'b0;
          if (!we_q) o_rdata <= ld_data;
          o_mem_addr  <= '0;
          o_mem_wdata <= '0;
          o_mem_bmask <= '0;
          wren_q      <= 1'b0;
        end
`endif

        RESP: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
